// File: rtl/pcm_pkg.sv
// Shared constants and arithmetic helpers for the PCM sound-effect mixer.
// Samples are unsigned with silence at midscale; mixing happens in two's complement.
package pcm_pkg;

    localparam int PCM_DW = 8;
    localparam logic [PCM_DW-1:0] PCM_MIDSCALE = 8'h80;

    // Accumulator must hold N_CH full-scale signed samples without wrapping.
    function automatic int pcm_acc_w(input int dw, input int n_ch);
        return dw + $clog2(n_ch) + 1;
    endfunction

    // Clamp a signed value into the signed range of a dw-bit sample.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/pcm_voice.sv
// One playback voice: trigger edge detect, pending/active state and sample position.
// A trigger only arms the voice; playback (re)starts at the next output tick.
module pcm_voice
    import pcm_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic          halt,
    input  logic          loop,
    input  logic [AW-1:0] length,
    input  logic          tick,
    input  logic          slot_done,
    output logic          active,
    output logic          busy,
    output logic [AW-1:0] pos
);

    logic          trig_q_r;
    logic          pending_r;
    logic          active_r;
    logic [AW-1:0] pos_r;
    logic          edge_s;
    logic          at_end_s;

    assign edge_s   = trig & ~trig_q_r;
    assign at_end_s = (pos_r == (length - AW'(1)));

    // Voice state: halt overrides everything, then tick start, then end-of-slot advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q_r  <= 1'b0;
            pending_r <= 1'b0;
            active_r  <= 1'b0;
            pos_r     <= {AW{1'b0}};
        end else begin
            trig_q_r <= trig;
            if (halt) begin
                pending_r <= 1'b0;
                active_r  <= 1'b0;
            end else begin
                pending_r <= (pending_r & ~tick) | (edge_s & (length != {AW{1'b0}}));
                if (tick && pending_r) begin
                    active_r <= 1'b1;
                    pos_r    <= {AW{1'b0}};
                end else if (slot_done && active_r) begin
                    if (at_end_s) begin
                        pos_r <= {AW{1'b0}};
                        if (!loop) begin
                            active_r <= 1'b0;
                        end
                    end else begin
                        pos_r <= pos_r + AW'(1);
                    end
                end
            end
        end
    end

    assign active = active_r;
    assign busy   = active_r | pending_r;
    assign pos    = pos_r;

endmodule

// File: rtl/pcm_sfx_mixer.sv
// Multi-voice PCM effect player: each output period the voices are scanned one per
// cycle through the shared ROM, attenuated, summed, saturated and emitted as one sample.
module pcm_sfx_mixer
    import pcm_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int AW      = 11,
    parameter int DW      = PCM_DW,
    parameter int CLK_DIV = 4000
) (
    input  logic              CLKSYS,
    input  logic              RESET,
    input  logic [N_CH-1:0]   trig,
    input  logic [N_CH-1:0]   halt,
    input  logic [N_CH-1:0]   loop,
    input  logic [N_CH*AW-1:0] start_addr,
    input  logic [N_CH*AW-1:0] length,
    input  logic [N_CH*2-1:0] vol,
    output logic [AW-1:0]     rom_addr,
    input  logic [DW-1:0]     rom_data,
    output logic [N_CH-1:0]   busy,
    output logic [DW-1:0]     audio,
    output logic              audio_valid
);

    localparam int ACC_W = pcm_acc_w(DW, N_CH);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PH_W  = $clog2(N_CH + 3);
    localparam int SW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [DW-1:0]   MID     = {1'b1, {(DW-1){1'b0}}};
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_CH + 2);

    logic [DIV_W-1:0]        div_r;
    logic                    run_r;
    logic [PH_W-1:0]         ph_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [AW-1:0]           rom_addr_r;
    logic [DW-1:0]           audio_r;
    logic                    valid_r;

    logic                    tick_s;
    logic [N_CH-1:0]         slot_done_s;
    logic [N_CH-1:0]         active_s;
    logic [AW-1:0]           pos_a   [N_CH];
    logic [AW-1:0]           start_a [N_CH];
    logic [1:0]              vol_a   [N_CH];
    logic [SW-1:0]           addr_idx_s;
    logic [SW-1:0]           acc_idx_s;
    logic signed [DW-1:0]    diff_s;
    logic signed [DW-1:0]    shift_s;
    logic signed [ACC_W-1:0] contrib_s;
    logic signed [31:0]      acc32_s;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_voice
            assign start_a[g] = start_addr[g*AW +: AW];
            assign vol_a[g]   = vol[g*2 +: 2];
            pcm_voice #(.AW(AW)) u_voice (
                .clk       (CLKSYS),
                .rst       (RESET),
                .trig      (trig[g]),
                .halt      (halt[g]),
                .loop      (loop[g]),
                .length    (length[g*AW +: AW]),
                .tick      (tick_s),
                .slot_done (slot_done_s[g]),
                .active    (active_s[g]),
                .busy      (busy[g]),
                .pos       (pos_a[g])
            );
        end
    endgenerate

    assign tick_s     = (div_r == DIV_W'(CLK_DIV - 1));
    assign addr_idx_s = ph_r[SW-1:0];
    assign acc_idx_s  = SW'(ph_r - PH_W'(2));
    // Offset-binary to two's complement is just an MSB flip.
    assign diff_s     = rom_data ^ MID;
    assign shift_s    = diff_s >>> vol_a[acc_idx_s];
    assign contrib_s  = {{(ACC_W-DW){shift_s[DW-1]}}, shift_s};
    assign acc32_s    = {{(32-ACC_W){acc_r[ACC_W-1]}}, acc_r};

    // Voice s finishes its slot once its ROM word has been accumulated.
    always_comb begin
        slot_done_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            slot_done_s[i] = run_r && (ph_r == PH_W'(i + 2));
        end
    end

    // Output-rate divider.
    always_ff @(posedge CLKSYS or posedge RESET) begin
        if (RESET) begin
            div_r <= {DIV_W{1'b0}};
        end else begin
            div_r <= tick_s ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
        end
    end

    // Scan sequencer: address phase, accumulate phase (ROM latency 1), then output.
    always_ff @(posedge CLKSYS or posedge RESET) begin
        if (RESET) begin
            run_r      <= 1'b0;
            ph_r       <= {PH_W{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            rom_addr_r <= {AW{1'b0}};
            audio_r    <= MID;
            valid_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (tick_s) begin
                run_r <= 1'b1;
                ph_r  <= {PH_W{1'b0}};
                acc_r <= {ACC_W{1'b0}};
            end else if (run_r) begin
                ph_r <= ph_r + PH_W'(1);
                if (ph_r < PH_W'(N_CH)) begin
                    rom_addr_r <= start_a[addr_idx_s] + pos_a[addr_idx_s];
                end
                if ((ph_r >= PH_W'(2)) && (ph_r < PH_LAST) && active_s[acc_idx_s]) begin
                    acc_r <= acc_r + contrib_s;
                end
                if (ph_r == PH_LAST) begin
                    run_r   <= 1'b0;
                    audio_r <= DW'(sat_signed(acc32_s, DW)) ^ MID;
                    valid_r <= 1'b1;
                end
            end
        end
    end

    assign rom_addr    = rom_addr_r;
    assign audio       = audio_r;
    assign audio_valid = valid_r;

endmodule

// File: tb/tb_pcm_sfx_mixer.sv
// Directed and randomized check of pcm_sfx_mixer against a per-sample-period voice model.
module tb_pcm_sfx_mixer;
    import pcm_pkg::*;

    localparam int N = 2, AW = 11, DW = 8, DIV = 16;

    logic           CLKSYS = 1'b0;
    logic           RESET  = 1'b1;
    logic [N-1:0]   trig, halt, loop;
    logic [N*AW-1:0] start_addr, length;
    logic [N*2-1:0] vol;
    logic [AW-1:0]  rom_addr;
    logic [DW-1:0]  rom_data;
    logic [N-1:0]   busy;
    logic [DW-1:0]  audio;
    logic           audio_valid;

    logic [7:0] rom [0:2047];
    int total = 0, bad = 0;
    int m_pend [N], m_act [N], m_pos [N];

    pcm_sfx_mixer #(.N_CH(N), .AW(AW), .DW(DW), .CLK_DIV(DIV)) dut (
        .CLKSYS(CLKSYS), .RESET(RESET), .trig(trig), .halt(halt), .loop(loop),
        .start_addr(start_addr), .length(length), .vol(vol), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy), .audio(audio), .audio_valid(audio_valid)
    );

    always #5 CLKSYS = ~CLKSYS;
    always @(posedge CLKSYS) rom_data <= rom[rom_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int c_start(input int c); return int'(start_addr[c*AW +: AW]); endfunction
    function automatic int c_len(input int c);   return int'(length[c*AW +: AW]);     endfunction
    function automatic int c_vol(input int c);   return int'(vol[c*2 +: 2]);          endfunction

    // One output period of the reference: start armed voices, mix, then advance.
    task automatic model_pulse(output int ea, output int eb);
        int sum, d;
        sum = 0;
        eb  = 0;
        for (int c = 0; c < N; c++) begin
            if (m_pend[c] != 0) begin
                m_act[c] = 1; m_pos[c] = 0; m_pend[c] = 0;
            end
        end
        for (int c = 0; c < N; c++) begin
            if (m_act[c] != 0) begin
                d = int'(rom[(c_start(c) + m_pos[c]) % 2048]) - 128;
                sum += d >>> c_vol(c);
                if (m_pos[c] == (c_len(c) + 2047) % 2048) begin
                    m_pos[c] = 0;
                    if (!loop[c]) m_act[c] = 0;
                end else begin
                    m_pos[c] = (m_pos[c] + 1) % 2048;
                end
            end
            if (m_act[c] != 0 || m_pend[c] != 0) eb |= (1 << c);
        end
        if (sum > 127) sum = 127;
        if (sum < -128) sum = -128;
        ea = sum + 128;
    endtask

    task automatic wait_pulse(output int cy);
        cy = 0;
        do begin
            @(negedge CLKSYS);
            cy++;
        end while (!audio_valid && cy < 64);
        if (!audio_valid) check("pulse_timeout", 32'd0, 32'd1);
    endtask

    task automatic step(input string tag, input int exp_const, output int cy);
        int ea, eb;
        wait_pulse(cy);
        model_pulse(ea, eb);
        check({tag, "_audio"}, audio, ea);
        check({tag, "_busy"}, busy, eb);
        if (exp_const >= 0) check({tag, "_const"}, audio, exp_const);
    endtask

    task automatic set_cfg(input int c, input int st, input int ln, input int v, input int lp);
        start_addr[c*AW +: AW] = AW'(st);
        length[c*AW +: AW]     = AW'(ln);
        vol[c*2 +: 2]          = 2'(v);
        loop[c]                = lp[0];
    endtask

    task automatic do_trig(input int c);
        trig[c] = 1'b0;
        @(negedge CLKSYS);
        trig[c] = 1'b1;
        if (c_len(c) != 0) m_pend[c] = 1;
        @(negedge CLKSYS);
    endtask

    task automatic do_halt(input int c);
        halt[c] = 1'b1;
        @(negedge CLKSYS);
        halt[c] = 1'b0;
        m_act[c] = 0; m_pend[c] = 0;
    endtask

    initial begin
        int cy, c;
        int seq [4];
        seq = '{32'h90, 32'hA0, 32'hB0, 32'hC0};
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) rom[i] = 8'(seq[i]);
        rom[16] = 8'hFF; rom[17] = 8'hFF; rom[32] = 8'hFF; rom[33] = 8'hFF;
        rom[48] = 8'h00; rom[49] = 8'h00; rom[64] = 8'h00; rom[65] = 8'h00;
        rom[80] = 8'hC0;
        trig = '0; halt = '0; loop = '0; start_addr = '0; length = '0; vol = '0;
        for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_act[i] = 0; m_pos[i] = 0; end

        repeat (3) @(negedge CLKSYS);
        check("rst_audio", audio, PCM_MIDSCALE);
        check("rst_busy", busy, 32'd0);
        check("rst_valid", audio_valid, 32'd0);
        check("rst_addr", rom_addr, 32'd0);
        RESET = 1'b0;

        // Idle bank: midscale, one pulse per divider period.
        step("idle0", 32'h80, cy);
        step("idle1", 32'h80, cy);
        check("period", cy, DIV);

        // One-shot.
        set_cfg(0, 0, 4, 0, 0);
        do_trig(0);
        for (int i = 0; i < 4; i++) step("oneshot", seq[i], cy);
        check("oneshot_busy0", busy[0], 32'd0);
        step("oneshot_end", 32'h80, cy);

        // Looping until halt.
        loop[0] = 1'b1;
        do_trig(0);
        for (int i = 0; i < 6; i++) step("loop", seq[i % 4], cy);
        do_halt(0);
        step("halted", 32'h80, cy);

        // Retrigger mid-play restarts at sample 0.
        do_trig(0);
        step("retrig_a", 32'h90, cy);
        step("retrig_b", 32'hA0, cy);
        do_trig(0);
        step("retrig_c", 32'h90, cy);
        do_halt(0);

        // Saturation both ways.
        set_cfg(0, 16, 2, 0, 0);
        set_cfg(1, 32, 2, 0, 0);
        do_trig(0); do_trig(1);
        step("sat_hi", 32'hFF, cy);
        step("sat_hi2", 32'hFF, cy);
        set_cfg(0, 48, 2, 0, 0);
        set_cfg(1, 64, 2, 0, 0);
        do_trig(0); do_trig(1);
        step("sat_lo", 32'h00, cy);
        step("sat_lo2", 32'h00, cy);

        // Attenuation, and a zero-length voice ignoring its trigger.
        set_cfg(0, 80, 1, 2, 0);
        set_cfg(1, 0, 0, 0, 0);
        do_trig(0); do_trig(1);
        check("len0_busy", busy[1], 32'd0);
        step("vol2", 32'h90, cy);
        check("len0_busy_after", busy[1], 32'd0);

        // Reset in the middle of a scan.
        set_cfg(0, 0, 4, 0, 1);
        do_trig(0);
        step("pre_rst", 32'h90, cy);
        repeat (12) @(negedge CLKSYS);
        RESET = 1'b1;
        trig = '0;
        #1;
        check("midrst_audio", audio, 32'h80);
        check("midrst_busy", busy, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLKSYS);
            check("midrst_valid", audio_valid, 32'd0);
        end
        for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_act[i] = 0; m_pos[i] = 0; end
        RESET = 1'b0;
        step("post_rst", 32'h80, cy);

        // Randomized traffic against the model.
        for (int it = 0; it < 150; it++) begin
            step("rand", -1, cy);
            for (int k = 0; k < 2; k++) begin
                c = $urandom_range(0, N - 1);
                case ($urandom_range(0, 5))
                    0, 1: do_trig(c);
                    2: if ($urandom_range(0, 3) == 0) do_halt(c);
                    3: if (m_act[c] == 0 && m_pend[c] == 0)
                           set_cfg(c, $urandom_range(0, 2047), $urandom_range(0, 9),
                                   $urandom_range(0, 3), $urandom_range(0, 1));
                    4: vol[c*2 +: 2] = 2'($urandom_range(0, 3));
                    default: loop[c] = 1'($urandom_range(0, 1));
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
